syn_check_sched: RTL and testbench

Round-robin scheduler that shares one combinational (15,7) cyclic-code syndrome detector among `N_REQ` codeword requesters. It accepts one codeword at a time over a valid/ready handshake and drives the codeword register into the external detector instance. It captures the 15-bit syndrome and error flag, returns them with the requester ID over a valid/ready response channel, and keeps a saturating per-requester error counter. It sits between the codeword sources (adder/CPE outputs) and the shared detector.

---
 rtl/syn_check_sched.sv | 149 ++++++++++++++
 tb/tb_syn_check_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_check_sched.sv
// rtl/syn_check_sched.sv - round-robin scheduler in front of a shared (15,7) syndrome detector
//
// Accepts one codeword at a time from N_REQ requesters, drives it into an
// external combinational syndrome detector, and returns the captured syndrome,
// error flag and requester ID on a valid/ready response channel. A saturating
// error counter is kept per requester.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot, combinational)
//   req_code             packed codewords, requester i at [15i+14:15i]
//   det_code             codeword register driven to the detector input
//   det_s, det_error     detector syndrome and error flag
//   rsp_valid/rsp_ready  response handshake
//   rsp_id, rsp_syndrome, rsp_error   captured response fields
//   cnt_clr              synchronous clear of all error counters
//   err_cnt              packed counters, requester i at [CNT_W*i+CNT_W-1:CNT_W*i]

module syn_check_sched #(
  parameter  int N_REQ = 4,
  parameter  int CNT_W = 8,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [15*N_REQ-1:0]      req_code,
  output logic [N_REQ-1:0]         req_ready,
  output logic [14:0]              det_code,
  input  logic [14:0]              det_s,
  input  logic                     det_error,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [14:0]              rsp_syndrome,
  output logic                     rsp_error,
  input  logic                     cnt_clr,
  output logic [CNT_W*N_REQ-1:0]   err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [IDW:0] N_REQ_W = (IDW+1)'(N_REQ);

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id_reg;
  logic [14:0]      code_reg;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_found;
  logic [IDW:0]     cand;
  logic [IDW:0]     id_inc;
  logic [IDW-1:0]   ptr_next;
  logic [14:0]      code_arr [N_REQ];
  logic [CNT_W-1:0] cnt      [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign code_arr[gi]                   = req_code[15*gi +: 15];
      assign err_cnt[CNT_W*gi +: CNT_W]     = cnt[gi];
    end
  endgenerate

  // Round-robin search: offsets are walked from the far end back toward ptr
  // so the closest valid requester (lowest offset) is the last to overwrite.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= N_REQ_W) begin
        cand = cand - N_REQ_W;
      end
      if (req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = cand[IDW-1:0];
      end
    end
  end

  // Gated with rst_n so nothing is offered while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == S_IDLE) && gnt_found) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  assign id_inc   = {1'b0, id_reg} + (IDW+1)'(1);
  assign ptr_next = (id_inc == N_REQ_W) ? '0 : id_inc[IDW-1:0];

  assign det_code  = code_reg;
  assign rsp_valid = (state == S_RESP);
  assign rsp_id    = id_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ptr          <= '0;
      id_reg       <= '0;
      code_reg     <= '0;
      rsp_syndrome <= '0;
      rsp_error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            code_reg <= code_arr[gnt_id];
            id_reg   <= gnt_id;
            state    <= S_EVAL;
          end
        end
        S_EVAL: begin
          // Detector is purely combinational off code_reg; sample its result here.
          rsp_syndrome <= det_s;
          rsp_error    <= det_error;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            ptr   <= ptr_next;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else if ((state == S_EVAL) && det_error && (cnt[id_reg] != {CNT_W{1'b1}})) begin
      cnt[id_reg] <= cnt[id_reg] + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_syn_check_sched.sv
// tb/tb_syn_check_sched.sv - self-checking bench for syn_check_sched

module tb_syn_check_sched;

  localparam int N  = 4;
  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [59:0] req_code;
  logic [3:0]  req_ready;
  logic [14:0] det_code;
  logic [14:0] det_s;
  logic        det_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [14:0] rsp_syndrome;
  logic        rsp_error;
  logic        cnt_clr;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  syn_check_sched #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_code     (req_code),
    .req_ready    (req_ready),
    .det_code     (det_code),
    .det_s        (det_s),
    .det_error    (det_error),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_syndrome (rsp_syndrome),
    .rsp_error    (rsp_error),
    .cnt_clr      (cnt_clr),
    .err_cnt      (err_cnt)
  );

  // Detector model: s(x) = c(x) * h(x) mod (x^15 - 1), h(x) = x^7+x^6+x^4+1.
  function automatic logic [14:0] syn(input logic [14:0] c);
    logic [14:0] h;
    logic [14:0] s;
    h = 15'h00D1;
    s = '0;
    for (int i = 0; i < 15; i++)
      for (int j = 0; j < 15; j++)
        if (c[i] && h[j]) s[(i + j) % 15] = ~s[(i + j) % 15];
    return s;
  endfunction

  assign det_s     = syn(det_code);
  assign det_error = |det_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack_cnt(input int c0, input int c1, input int c2, input int c3);
    return {2'(c3), 2'(c2), 2'(c1), 2'(c0)};
  endfunction

  function automatic logic [14:0] pick();
    case ($urandom_range(0, 5))
      0:       return 15'h0000;
      1:       return 15'h01D1;
      2:       return 15'h7FFF;
      default: return 15'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_req(input int id, input logic [14:0] code, input logic [14:0] esyn,
                        input logic eerr, input int stall, input bit clr_eval);
    int n;
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    @(negedge clk);
    req_valid = onehot;
    req_code  = '0;
    req_code[15*id +: 15] = code;
    rsp_ready = (stall == 0);
    #1;
    n = 0;
    while (req_ready !== onehot && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept", 32'(req_ready), 32'(onehot));
    @(negedge clk);
    req_valid = '0;
    cnt_clr   = clr_eval;
    #1;
    chk("eval_no_rsp", 32'(rsp_valid), 0);
    chk("det_code", 32'(det_code), 32'(code));
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_syndrome", 32'(rsp_syndrome), 32'(esyn));
    chk("rsp_error", 32'(rsp_error), 32'(eerr));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (s == stall - 1) rsp_ready = 1'b1;
      #1;
      chk("stall_hold", {rsp_valid, rsp_id, rsp_error, rsp_syndrome},
          {1'b1, 2'(id), eerr, esyn});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("back_idle", 32'(rsp_valid), 0);
  endtask

  typedef struct {
    int          id;
    logic [14:0] code;
    logic [14:0] esyn;
    logic        eerr;
    int          stall;
  } vec_t;

  vec_t vt [6];
  int   e_cnt [4];
  int   exp_ids [5];
  logic [14:0] rr_code [4];
  logic [14:0] acc_code;
  logic [3:0]  v;
  logic [14:0] rc [4];
  int m_ptr, m_phase, m_id, g;
  logic [14:0] m_code;
  int n_wait;

  initial begin
    vt[0] = '{2, 15'h0000, 15'h0000, 1'b0, 0};
    vt[1] = '{1, 15'h0001, 15'h00D1, 1'b1, 0};
    vt[2] = '{3, 15'h4000, 15'h4068, 1'b1, 3};
    vt[3] = '{0, 15'h01D1, 15'h0000, 1'b0, 0};
    vt[4] = '{2, 15'h7FFF, 15'h0000, 1'b0, 1};
    vt[5] = '{0, 15'h0003, 15'h0173, 1'b1, 0};
    exp_ids = '{0, 1, 2, 3, 0};

    // Reset state with all requesters valid
    rst_n = 1'b0; req_valid = 4'hF; req_code = {4{15'h1234}}; rsp_ready = 1'b1; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_det_code", 32'(det_code), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_rsp_fields", {rsp_error, rsp_syndrome}, 0);
    rst_n = 1'b1;
    #1;
    chk("first_idle_grant", 32'(req_ready), 32'h1);
    req_valid = '0;

    // Directed single transactions
    for (int i = 0; i < 4; i++) e_cnt[i] = 0;
    for (int i = 0; i < 6; i++) begin
      do_req(vt[i].id, vt[i].code, vt[i].esyn, vt[i].eerr, vt[i].stall, 1'b0);
      if (vt[i].eerr && e_cnt[vt[i].id] < 3) e_cnt[vt[i].id]++;
      chk("vec_err_cnt", 32'(err_cnt), 32'(pack_cnt(e_cnt[0], e_cnt[1], e_cnt[2], e_cnt[3])));
    end

    // Round robin with 5-cycle backpressure per response
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rr_code[i] = pick();
      req_code[15*i +: 15] = rr_code[i];
    end
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << exp_ids[t]));
      acc_code = rr_code[exp_ids[t]];
      @(negedge clk);
      rr_code[exp_ids[t]] = pick();
      req_code[15*exp_ids[t] +: 15] = rr_code[exp_ids[t]];
      @(negedge clk);
      #1;
      chk("rr_rsp", {rsp_valid, rsp_id, rsp_error, rsp_syndrome},
          {1'b1, 2'(exp_ids[t]), |syn(acc_code), syn(acc_code)});
      for (int s = 0; s < 5; s++) begin
        @(negedge clk);
        if (s == 4) rsp_ready = 1'b1;
        #1;
        chk("rr_stall_ready", 32'(req_ready), 0);
        chk("rr_stall_hold", {rsp_valid, rsp_id, rsp_error, rsp_syndrome},
            {1'b1, 2'(exp_ids[t]), |syn(acc_code), syn(acc_code)});
      end
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    req_valid = '0;

    // Counter saturation, then clear coinciding with an erroring EVAL
    do_reset();
    for (int i = 0; i < 5; i++) do_req(0, 15'h0001, 15'h00D1, 1'b1, 0, 1'b0);
    chk("sat_cnt0", 32'(err_cnt[1:0]), 3);
    do_req(0, 15'h0001, 15'h00D1, 1'b1, 0, 1'b1);
    chk("clr_wins", 32'(err_cnt), 0);

    // Reset during RESP
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010; req_code = '0; req_code[29:15] = 15'h0001; rsp_ready = 1'b0;
    #1;
    chk("mid_accept", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("mid_in_resp", 32'(rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rsp_drop", 32'(rsp_valid), 0);
    chk("mid_state_clear", {det_code, rsp_syndrome, err_cnt}, 0);
    req_valid = 4'hF;
    #0;
    chk("mid_ready_in_rst", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_ptr_zero", 32'(req_ready), 32'h1);
    req_valid = '0;

    // Randomized traffic against a transaction-level model
    do_reset();
    v = '0;
    m_ptr = 0; m_phase = 0; m_id = 0; m_code = '0;
    for (int i = 0; i < 4; i++) begin e_cnt[i] = 0; rc[i] = '0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          rc[i] = pick();
        end
        req_code[15*i +: 15] = rc[i];
      end
      req_valid = v;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 40) == 0);
      #1;
      g = -1;
      if (m_phase == 0)
        for (int k = 0; k < 4; k++)
          if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      chk("rnd_ready", 32'(req_ready), (g >= 0) ? 32'(4'b0001 << g) : 0);
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      if (m_phase == 2)
        chk("rnd_rsp", {rsp_id, rsp_error, rsp_syndrome}, {2'(m_id), |syn(m_code), syn(m_code)});
      chk("rnd_cnt", 32'(err_cnt), 32'(pack_cnt(e_cnt[0], e_cnt[1], e_cnt[2], e_cnt[3])));
      case (m_phase)
        0: if (g >= 0) begin m_id = g; m_code = rc[g]; v[g] = 1'b0; m_phase = 1; end
        1: begin
          if (syn(m_code) != 0 && e_cnt[m_id] < 3) e_cnt[m_id]++;
          m_phase = 2;
        end
        default: if (rsp_ready) begin m_ptr = (m_id + 1) % 4; m_phase = 0; end
      endcase
      if (cnt_clr) for (int i = 0; i < 4; i++) e_cnt[i] = 0;
    end
    @(negedge clk);
    req_valid = '0; cnt_clr = 1'b0;
    // Drain any in-flight transaction so the bench ends idle
    rsp_ready = 1'b1;
    n_wait = 0;
    while (rsp_valid !== 1'b0 && n_wait < 10) begin @(negedge clk); n_wait++; end
    #1;
    chk("drain_idle", 32'(rsp_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
